// File: rtl/colour_symbol_decoder_pkg.sv
// colour_symbol_decoder_pkg: colour codes, ASCII table and FSM state type shared by the colour link.
package colour_symbol_decoder_pkg;

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [2:0] COL_A     = 3'b100;
    localparam logic [2:0] COL_B     = 3'b010;
    localparam logic [2:0] COL_C     = 3'b001;
    localparam logic [2:0] COL_D     = 3'b101;
    localparam logic [2:0] COL_E     = 3'b110;
    localparam logic [2:0] COL_F     = 3'b011;
    localparam logic [2:0] COL_SPACE = 3'b111;
    localparam logic [2:0] COL_OFF   = 3'b000;
    localparam logic [7:0] ASCII_ERR = 8'h3F;

    // An unlit symbol (and anything unexpected) decodes to '?'.
    function automatic logic [7:0] decode(input logic [2:0] c);
        case (c)
            COL_A:     decode = "A";
            COL_B:     decode = "B";
            COL_C:     decode = "C";
            COL_D:     decode = "D";
            COL_E:     decode = "E";
            COL_F:     decode = "F";
            COL_SPACE: decode = " ";
            default:   decode = ASCII_ERR;
        endcase
    endfunction

endpackage

// File: rtl/colour_symbol_decoder_sync.sv
// colour_sync: two-flop synchroniser for the asynchronous 3-bit colour input.
module colour_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] d_i,
    output logic [2:0] q_o
);

    logic [2:0] meta_q;
    logic [2:0] sync_q;

    // Two flop stages settle metastability before the colour is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/colour_symbol_decoder.sv
// colour_symbol_decoder: recovers ASCII from an RGB colour stream and flags a target message.
module colour_symbol_decoder
    import colour_symbol_decoder_pkg::*;
#(
    parameter int                           SYMBOL_CYCLES   = 48_000_001,
    parameter int                           SAMPLE_POINT    = 24_000_000,
    parameter int                           MESSAGELENGTH   = 14,
    parameter logic [8*MESSAGELENGTH-1:0]   EXPECTED        = "DEAD BEEF CAFE",
    parameter int                           TIMEOUT_SYMBOLS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] colour_in,
    output logic [7:0] char_out,
    output logic       char_valid,
    output logic       match,
    output logic       locked,
    output logic [7:0] err_count
);

    localparam int PW = $clog2(SYMBOL_CYCLES);
    localparam int HW = 8 * MESSAGELENGTH;
    localparam int OW = $clog2(TIMEOUT_SYMBOLS + 1);

    logic [2:0]    col_s, col_p_q;
    logic [PW-1:0] ph_q, ph_d;
    state_e        state_q, state_d;
    logic [7:0]    char_q, char_d, err_q, err_d, code;
    logic [HW-1:0] hist_q, hist_d;
    logic [OW-1:0] off_q, off_d;
    logic          valid_q, match_q, match_d, locked_q;
    logic          col_edge, start, emit, is_err, timeout;

    colour_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (colour_in),
        .q_o (col_s)
    );

    assign col_edge = col_s != col_p_q;
    assign code     = decode(col_s);
    assign is_err   = code == ASCII_ERR;
    assign start    = state_q == IDLE && col_edge && col_s != COL_OFF;
    assign emit     = state_q == RUN && !col_edge && ph_q == PW'(SAMPLE_POINT - 1);
    assign timeout  = emit && is_err && off_q == OW'(TIMEOUT_SYMBOLS - 1);
    assign ph_d     = (col_edge || ph_q == PW'(SYMBOL_CYCLES - 1)) ? '0 : ph_q + PW'(1);

    // Symbol phase restarts on every colour edge so sampling tracks the transmitter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_p_q <= '0;
            ph_q    <= '0;
        end else begin
            col_p_q <= col_s;
            ph_q    <= ph_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Lock on the first lit colour edge; drop lock after too many dark symbols.
    always_comb begin
        state_d = start ? RUN : timeout ? IDLE : state_q;
    end

    // Next values for the decoded character, history and counters.
    always_comb begin
        char_d  = emit ? code : char_q;
        hist_d  = start ? '0 : emit ? HW'({hist_q, code}) : hist_q;
        off_d   = (!emit || timeout || !is_err) ? (emit ? '0 : off_q) : off_q + OW'(1);
        err_d   = (emit && is_err && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        match_d = valid_q && hist_q == EXPECTED;
    end

    // Output and history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_q   <= '0;
            valid_q  <= 1'b0;
            hist_q   <= '0;
            off_q    <= '0;
            err_q    <= '0;
            match_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            char_q   <= char_d;
            valid_q  <= emit;
            hist_q   <= hist_d;
            off_q    <= off_d;
            err_q    <= err_d;
            match_q  <= match_d;
            locked_q <= state_q == RUN;
        end
    end

    assign char_out   = char_q;
    assign char_valid = valid_q;
    assign match      = match_q;
    assign locked     = locked_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_colour_symbol_decoder.sv
// tb_colour_symbol_decoder: scoreboard bench for the colour symbol decoder.
module tb_colour_symbol_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] colour_in = 3'b000;
    logic [7:0] char_out, err_count;
    logic       char_valid, match, locked;

    colour_symbol_decoder #(
        .SYMBOL_CYCLES   (16),
        .SAMPLE_POINT    (8),
        .MESSAGELENGTH   (4),
        .EXPECTED        ("DEAD"),
        .TIMEOUT_SYMBOLS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .colour_in  (colour_in),
        .char_out   (char_out),
        .char_valid (char_valid),
        .match      (match),
        .locked     (locked),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] ch;
        int         due;
        logic [7:0] err;
        logic       m;
    } exp_t;

    exp_t        sb[$];
    int          passed = 0;
    int          total = 0;
    logic [31:0] hist_m = '0;
    logic [7:0]  err_m = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic expect_char(input logic [7:0] ch, input int due);
        exp_t e;
        hist_m = {hist_m[23:0], ch};
        if (ch == 8'h3F && err_m != 8'hFF) err_m++;
        e.ch  = ch;
        e.due = due;
        e.err = err_m;
        e.m   = (hist_m == "DEAD");
        sb.push_back(e);
    endtask

    // Drive one colour for hold cycles, expecting n emits of ch 11 cycles after the change, then every 16.
    task automatic sym(input logic [2:0] c, input int hold, input logic [7:0] ch, input int n);
        int t0;
        colour_in = c;
        t0 = cyc;
        for (int k = 0; k < n; k++) expect_char(ch, t0 + 11 + 16 * k);
        repeat (hold) @(negedge clk);
    endtask

    logic exp_match = 1'b0;
    logic prev_v = 1'b0;

    // Monitor: every strobe pops the scoreboard; match is checked the cycle after each strobe and whenever it rises.
    always @(negedge clk) begin
        exp_t e;
        if (match !== exp_match || exp_match || prev_v) chk("match", {31'b0, match}, {31'b0, exp_match});
        exp_match = 1'b0;
        prev_v = char_valid;
        if (char_valid) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_strobe: got char %0h with nothing expected (cycle %0d)", char_out, cyc);
            end else begin
                e = sb.pop_front();
                chk("char", {24'b0, char_out}, {24'b0, e.ch});
                chk("strobe_cycle", cyc, e.due);
                chk("err_count", {24'b0, err_count}, {24'b0, e.err});
                chk("locked_at_strobe", {31'b0, locked}, 32'd1);
                exp_match = e.m;
            end
        end
    end

    initial begin
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            colour_in = 3'(i + 1);
            chk("rst_valid", {31'b0, char_valid}, 32'd0);
            chk("rst_locked", {31'b0, locked}, 32'd0);
        end
        chk("rst_char", {24'b0, char_out}, 32'd0);
        chk("rst_err", {24'b0, err_count}, 32'd0);
        colour_in = 3'b000;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_locked", {31'b0, locked}, 32'd0);
        chk("idle_char", {24'b0, char_out}, 32'd0);

        sym(3'b101, 16, "D", 1);
        sym(3'b110, 16, "E", 1);
        sym(3'b100, 16, "A", 1);
        sym(3'b101, 16, "D", 1);

        sym(3'b110, 48, "E", 3);

        sym(3'b000, 27, "?", 2);
        chk("locked_last_off", {31'b0, locked}, 32'd1);
        @(negedge clk);
        chk("locked_dropped", {31'b0, locked}, 32'd0);
        chk("err_after_off", {24'b0, err_count}, 32'd2);
        repeat (4) @(negedge clk);
        hist_m = '0;
        sym(3'b100, 16, "A", 1);
        chk("relocked", {31'b0, locked}, 32'd1);

        colour_in = 3'b101;
        repeat (4) @(negedge clk);
        colour_in = 3'b011;
        @(negedge clk);
        sym(3'b101, 16, "D", 1);

        colour_in = 3'b110;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        colour_in = 3'b000;
        @(negedge clk);
        chk("mid_rst_char", {24'b0, char_out}, 32'd0);
        chk("mid_rst_err", {24'b0, err_count}, 32'd0);
        chk("mid_rst_locked", {31'b0, locked}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_locked", {31'b0, locked}, 32'd0);
        chk("post_rst_err", {24'b0, err_count}, 32'd0);
        chk("post_rst_char", {24'b0, char_out}, 32'd0);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
